// File: rtl/dff_mem_arbiter_if.sv
// rtl/dff_mem_arbiter_if.sv - request, response and memory-pin bundle for the DFF scratch memory arbiter
// Requesters and the memory macro sit on the master side; the arbiter takes the slave modport.
interface dff_mem_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;

  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;

  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              init_busy;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  mem_rdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    output mem_we, mem_re, mem_addr, mem_wdata,
    output init_busy
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output mem_rdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    input  mem_we, mem_re, mem_addr, mem_wdata,
    input  init_busy
  );
endinterface

// File: rtl/dff_mem_arbiter.sv
// rtl/dff_mem_arbiter.sv - clear-on-reset round-robin arbiter for the single-port DFF scratch memory
// Two requesters share the memory; strobes are registered and read data is routed back by tag.
module dff_mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  dff_mem_arbiter_if.slave      bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_next;
  logic              prio, prio_next;

  logic              ready0, ready1;
  logic              grant0, grant1;
  logic              mem_we_next, mem_re_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_next;
  logic              rd_id, rd_id_next;

  // Read tag pipeline: stage 1 follows mem_re, stage 2 holds the captured read data.
  logic              tag1_valid, tag1_id;
  logic              tag2_valid, tag2_id;
  logic [DATA_W-1:0] tag2_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
      prio    <= 1'b0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
      prio    <= prio_next;
    end
  end

  always_comb begin
    state_next     = state;
    clr_cnt_next   = clr_cnt;
    prio_next      = prio;
    ready0         = 1'b0;
    ready1         = 1'b0;
    grant0         = 1'b0;
    grant1         = 1'b0;
    mem_we_next    = 1'b0;
    mem_re_next    = 1'b0;
    mem_addr_next  = bus.mem_addr;
    mem_wdata_next = bus.mem_wdata;
    rd_id_next     = rd_id;

    case (state)
      ST_INIT: begin
        mem_we_next    = 1'b1;
        mem_addr_next  = clr_cnt;
        mem_wdata_next = '0;
        clr_cnt_next   = clr_cnt + 1'b1;
        if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
          state_next = ST_RUN;
        end
      end

      ST_RUN: begin
        // Readiness never looks at the requester's own valid, so a lone requester is always ready.
        ready0 = !bus.req1_valid || !prio;
        ready1 = !bus.req0_valid ||  prio;
        grant0 = bus.req0_valid && ready0;
        grant1 = bus.req1_valid && ready1;

        if (grant0) begin
          mem_we_next   = bus.req0_we;
          mem_re_next   = !bus.req0_we;
          mem_addr_next = bus.req0_addr;
          if (bus.req0_we) begin
            mem_wdata_next = bus.req0_wdata;
          end else begin
            rd_id_next = 1'b0;
          end
          prio_next = 1'b1;
        end else if (grant1) begin
          mem_we_next   = bus.req1_we;
          mem_re_next   = !bus.req1_we;
          mem_addr_next = bus.req1_addr;
          if (bus.req1_we) begin
            mem_wdata_next = bus.req1_wdata;
          end else begin
            rd_id_next = 1'b1;
          end
          prio_next = 1'b0;
        end
      end

      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_we     <= 1'b0;
      bus.mem_re     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      rd_id          <= 1'b0;
      tag1_valid     <= 1'b0;
      tag1_id        <= 1'b0;
      tag2_valid     <= 1'b0;
      tag2_id        <= 1'b0;
      tag2_data      <= '0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp0_rdata <= '0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp1_rdata <= '0;
    end else begin
      bus.mem_we    <= mem_we_next;
      bus.mem_re    <= mem_re_next;
      bus.mem_addr  <= mem_addr_next;
      bus.mem_wdata <= mem_wdata_next;
      rd_id         <= rd_id_next;

      tag1_valid <= bus.mem_re;
      tag1_id    <= rd_id;
      tag2_valid <= tag1_valid;
      tag2_id    <= tag1_id;
      // Memory output is only valid for one cycle; grab it alongside the tag so back-to-back reads survive.
      tag2_data  <= bus.mem_rdata;

      bus.rsp0_valid <= tag2_valid && !tag2_id;
      bus.rsp1_valid <= tag2_valid &&  tag2_id;
      if (tag2_valid && !tag2_id) begin
        bus.rsp0_rdata <= tag2_data;
      end
      if (tag2_valid && tag2_id) begin
        bus.rsp1_rdata <= tag2_data;
      end
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.init_busy  = (state == ST_INIT);

endmodule

// File: tb/tb_dff_mem_arbiter.sv
// tb/tb_dff_mem_arbiter.sv - directed self-checking bench for dff_mem_arbiter
// Includes a registered-output memory model that powers up full of 0xEE.
module tb_dff_mem_arbiter;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dff_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dff_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DATA_W-1:0] mem_model [16];

  initial begin
    for (int i = 0; i < 16; i++) mem_model[i] = 8'hEE;
    bus.mem_rdata = 8'h00;
  end

  always @(posedge clk) begin
    if (bus.mem_we) mem_model[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem_model[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req0(input logic v, input logic we, input logic [3:0] a, input logic [7:0] d);
    bus.req0_valid = v;
    bus.req0_we    = we;
    bus.req0_addr  = a;
    bus.req0_wdata = d;
  endtask

  task automatic req1(input logic v, input logic we, input logic [3:0] a, input logic [7:0] d);
    bus.req1_valid = v;
    bus.req1_we    = we;
    bus.req1_addr  = a;
    bus.req1_wdata = d;
  endtask

  initial begin
    req0(1'b0, 1'b0, 4'd0, 8'h00);
    req1(1'b0, 1'b0, 4'd0, 8'h00);
    rst = 1'b1;
    tick();
    tick();

    check("rst_mem_we",     bus.mem_we,     0);
    check("rst_mem_re",     bus.mem_re,     0);
    check("rst_mem_addr",   bus.mem_addr,   0);
    check("rst_mem_wdata",  bus.mem_wdata,  0);
    check("rst_rsp0_valid", bus.rsp0_valid, 0);
    check("rst_rsp1_valid", bus.rsp1_valid, 0);
    check("rst_rsp0_rdata", bus.rsp0_rdata, 0);
    check("rst_rsp1_rdata", bus.rsp1_rdata, 0);
    check("rst_init_busy",  bus.init_busy,  1);
    check("rst_req0_ready", bus.req0_ready, 0);
    check("rst_req1_ready", bus.req1_ready, 0);

    // Clear sweep after reset release
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("init_we",    bus.mem_we,    1);
      check("init_re",    bus.mem_re,    0);
      check("init_addr",  bus.mem_addr,  i);
      check("init_wdata", bus.mem_wdata, 0);
      check("init_busy",  bus.init_busy, (i < 15) ? 1 : 0);
      if (i == 4) begin
        req0(1'b1, 1'b0, 4'd2, 8'h00);
        req1(1'b1, 1'b0, 4'd3, 8'h00);
        #1;
        check("init_ready0", bus.req0_ready, 0);
        check("init_ready1", bus.req1_ready, 0);
        req0(1'b0, 1'b0, 4'd0, 8'h00);
        req1(1'b0, 1'b0, 4'd0, 8'h00);
      end
    end
    tick();
    check("idle_we", bus.mem_we, 0);
    check("idle_re", bus.mem_re, 0);

    // Read address 5 after clear
    req0(1'b1, 1'b0, 4'd5, 8'h00);
    #1;
    check("rd5_ready", bus.req0_ready, 1);
    tick();
    req0(1'b0, 1'b0, 4'd0, 8'h00);
    check("rd5_mem_re",   bus.mem_re,   1);
    check("rd5_mem_we",   bus.mem_we,   0);
    check("rd5_mem_addr", bus.mem_addr, 5);
    tick();
    tick();
    check("rd5_early", bus.rsp0_valid, 0);
    tick();
    check("rd5_valid", bus.rsp0_valid, 1);
    check("rd5_rdata", bus.rsp0_rdata, 8'h00);
    check("rd5_rsp1",  bus.rsp1_valid, 0);
    tick();
    check("rd5_pulse", bus.rsp0_valid, 0);

    // Write 0xA5 to 3 then read it back immediately
    req0(1'b1, 1'b1, 4'd3, 8'hA5);
    tick();
    check("wr3_we",    bus.mem_we,    1);
    check("wr3_addr",  bus.mem_addr,  3);
    check("wr3_wdata", bus.mem_wdata, 8'hA5);
    req0(1'b1, 1'b0, 4'd3, 8'h00);
    tick();
    req0(1'b0, 1'b0, 4'd0, 8'h00);
    check("rd3_re", bus.mem_re, 1);
    check("rd3_we", bus.mem_we, 0);
    tick();
    tick();
    check("rd3_early", bus.rsp0_valid, 0);
    tick();
    check("rd3_valid", bus.rsp0_valid, 1);
    check("rd3_rdata", bus.rsp0_rdata, 8'hA5);
    check("rd3_rsp1",  bus.rsp1_valid, 0);
    tick();
    check("rd3_pulse", bus.rsp0_valid, 0);
    check("rd3_rsp1b", bus.rsp1_valid, 0);

    // Preload 0x11 @1 (req0) and 0x22 @2 (req1); leaves priority at requester 0
    req0(1'b1, 1'b1, 4'd1, 8'h11);
    tick();
    req0(1'b0, 1'b0, 4'd0, 8'h00);
    req1(1'b1, 1'b1, 4'd2, 8'h22);
    tick();
    req1(1'b0, 1'b0, 4'd0, 8'h00);

    // Contending reads: grants alternate, responses alternate one per cycle
    req0(1'b1, 1'b0, 4'd1, 8'h00);
    req1(1'b1, 1'b0, 4'd2, 8'h00);
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        #1;
        check("rr_ready0", bus.req0_ready, (k % 2 == 0) ? 1 : 0);
        check("rr_ready1", bus.req1_ready, (k % 2 == 1) ? 1 : 0);
      end
      tick();
      if (k == 3) begin
        req0(1'b0, 1'b0, 4'd0, 8'h00);
        req1(1'b0, 1'b0, 4'd0, 8'h00);
      end
      if (k < 4) begin
        check("rr_mem_re",   bus.mem_re,   1);
        check("rr_mem_addr", bus.mem_addr, (k % 2 == 0) ? 1 : 2);
      end else begin
        check("rr_mem_idle", bus.mem_re, 0);
      end
      if (k >= 3 && k <= 6) begin
        check("rr_rsp0_valid", bus.rsp0_valid, ((k - 3) % 2 == 0) ? 1 : 0);
        check("rr_rsp1_valid", bus.rsp1_valid, ((k - 3) % 2 == 1) ? 1 : 0);
        if ((k - 3) % 2 == 0) check("rr_rsp0_rdata", bus.rsp0_rdata, 8'h11);
        else                  check("rr_rsp1_rdata", bus.rsp1_rdata, 8'h22);
      end else begin
        check("rr_rsp0_quiet", bus.rsp0_valid, 0);
        check("rr_rsp1_quiet", bus.rsp1_valid, 0);
      end
    end

    // Lone requester 1 for 4 cycles
    for (int k = 0; k < 4; k++) begin
      req1(1'b1, 1'b1, 4'(8 + k), 8'(8'h80 + k));
      #1;
      check("solo_ready1", bus.req1_ready, 1);
      tick();
      check("solo_we",   bus.mem_we,   1);
      check("solo_addr", bus.mem_addr, 8 + k);
    end
    req1(1'b0, 1'b0, 4'd0, 8'h00);
    req0(1'b1, 1'b0, 4'd0, 8'h00);
    req1(1'b1, 1'b0, 4'd0, 8'h00);
    #1;
    check("solo_prio_ready0", bus.req0_ready, 1);
    check("solo_prio_ready1", bus.req1_ready, 0);
    req0(1'b0, 1'b0, 4'd0, 8'h00);
    req1(1'b0, 1'b0, 4'd0, 8'h00);

    // Same-cycle writes to 15 with priority on requester 1
    req0(1'b1, 1'b1, 4'd7, 8'h77);
    tick();
    req0(1'b1, 1'b1, 4'd15, 8'hC3);
    req1(1'b1, 1'b1, 4'd15, 8'h3C);
    #1;
    check("col_ready0", bus.req0_ready, 0);
    check("col_ready1", bus.req1_ready, 1);
    tick();
    check("col_first_addr",  bus.mem_addr,  15);
    check("col_first_wdata", bus.mem_wdata, 8'h3C);
    req1(1'b0, 1'b0, 4'd0, 8'h00);
    #1;
    check("col_ready0b", bus.req0_ready, 1);
    tick();
    req0(1'b0, 1'b0, 4'd0, 8'h00);
    check("col_second_we",    bus.mem_we,    1);
    check("col_second_wdata", bus.mem_wdata, 8'hC3);
    req1(1'b1, 1'b0, 4'd15, 8'h00);
    tick();
    req1(1'b0, 1'b0, 4'd0, 8'h00);
    tick();
    tick();
    tick();
    check("col_rd_valid", bus.rsp1_valid, 1);
    check("col_rd_rdata", bus.rsp1_rdata, 8'hC3);
    check("col_rd_rsp0",  bus.rsp0_valid, 0);

    // Reset with two reads in flight after writing 0xFF to 9
    req0(1'b1, 1'b1, 4'd9, 8'hFF);
    tick();
    req0(1'b1, 1'b0, 4'd9, 8'h00);
    tick();
    req0(1'b0, 1'b0, 4'd0, 8'h00);
    req1(1'b1, 1'b0, 4'd9, 8'h00);
    tick();
    req1(1'b0, 1'b0, 4'd0, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_re",   bus.mem_re,     0);
    check("mid_rst_we",   bus.mem_we,     0);
    check("mid_rst_addr", bus.mem_addr,   0);
    check("mid_rst_rsp0", bus.rsp0_valid, 0);
    check("mid_rst_rsp1", bus.rsp1_valid, 0);
    check("mid_rst_busy", bus.init_busy,  1);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("reinit_we",   bus.mem_we,     1);
      check("reinit_addr", bus.mem_addr,   i);
      check("reinit_rsp0", bus.rsp0_valid, 0);
      check("reinit_rsp1", bus.rsp1_valid, 0);
    end
    check("reinit_busy", bus.init_busy, 0);
    req0(1'b1, 1'b0, 4'd9, 8'h00);
    tick();
    req0(1'b0, 1'b0, 4'd0, 8'h00);
    tick();
    tick();
    tick();
    check("reinit_rd_valid", bus.rsp0_valid, 1);
    check("reinit_rd_rdata", bus.rsp0_rdata, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
